store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- Store-side counterpart of the load path's sign/zero extension: narrows a 32-bit register value to byte, halfword or word and drives a data-memory write.
- Performs byte-lane replication, byte-enable generation, alignment checking and a req/ack handshake to data memory with timeout.
- Sits between the EX/MEM stage (sb/sh/sw) and the data memory port.
- One store is in flight at a time.

Parameters:
- MAX_WAIT, 15: cycles mem_req may stay high without mem_ack before a timeout error (legal range 1..255).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- st_valid  input  1  store request from the pipeline.
- st_ready  output  1  unit can accept a request (high only in IDLE).
- st_addr  input  32  byte address.
- st_data  input  32  register value to store (rt).
- st_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- mem_req  output  1  write request to data memory.
- mem_addr  output  32  word-aligned address {st_addr[31:2],2'b00}.
- mem_wdata  output  32  lane-replicated write data.
- mem_be  output  4  byte enables; bit3 = bits 31:24.
- mem_ack  input  1  memory has completed the write.
- done  output  1  one-cycle pulse, store completed.
- err  output  1  one-cycle pulse, store rejected or aborted.
- err_code  output  2  01 misaligned, 10 reserved size, 11 timeout; valid while err=1, 00 otherwise.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE immediately.
  - mem_req, mem_be, done, err go to 0; err_code=00; mem_addr=0; mem_wdata=0; wait counter=0.
  - st_ready=1.
  - Reset mid-transaction abandons the store silently: no done, no err.
- States: IDLE, REQ, RESP.
- Accept: a request is accepted when st_valid and st_ready are both 1 at a rising edge.
- Legality check at accept:
  - size 11 → err_code 10.
  - halfword with st_addr[0]=1 → err_code 01.
  - word with st_addr[1:0]≠00 → err_code 01.
  - Reserved size takes priority over misalignment.
- Illegal request:
  - Next state is RESP with err=1 and the error code for one cycle.
  - mem_req is never asserted for it.
- Legal request: next state is REQ; mem_req=1 from the cycle after acceptance (one-cycle latency). Registered outputs are:
  - Byte: mem_wdata={4{st_data[7:0]}}; mem_be=4'b1000>>st_addr[1:0] (big-endian, addr 0 → bits 31:24).
  - Halfword: mem_wdata={2{st_data[15:0]}}; mem_be=1100 if st_addr[1]=0, else 0011.
  - Word: mem_wdata=st_data; mem_be=1111.
- REQ:
  - mem_req, mem_addr, mem_wdata and mem_be are held stable until exit.
  - Each cycle with mem_req=1 and mem_ack=0 increments the wait counter.
  - mem_ack=1 → RESP with done=1; mem_req drops at that edge.
  - If the counter has reached MAX_WAIT-1 and mem_ack=0 in the current cycle → RESP with err=1, err_code=11; mem_req drops.
  - mem_req is therefore high for at most MAX_WAIT cycles.
  - mem_ack arriving in the final allowed cycle counts as success.
- RESP:
  - Lasts exactly one cycle: done or err is high, st_ready=0, mem_be=0.
  - Then returns to IDLE. The wait counter clears on entry to IDLE.
- IDLE:
  - st_ready=1; mem_req=0; mem_be=0.
  - mem_addr and mem_wdata keep their last values.
  - mem_ack is ignored.
- Throughput: one store per 3 cycles minimum (accept edge, REQ cycle with immediate ack, RESP cycle).
- done and err are never high in the same cycle.

Test Plan:
- sb: st_addr=0x00001003, st_data=0xAABBCCDD, mem_ack on 3rd REQ cycle → mem_addr=0x00001000, mem_be=0001, mem_wdata=0xDDDDDDDD, mem_req high 3 cycles, then done=1 for 1 cycle, then st_ready=1.
- sh aligned/misaligned:
  - st_addr=0x00002002, st_data=0x12345678, immediate ack → mem_be=0011, mem_wdata=0x56785678, done pulse.
  - st_addr=0x00002001 → err=1, err_code=01, mem_req never high.
- sw with immediate ack: st_addr=0x00003000, data=0xCAFEF00D → mem_be=1111, done exactly 2 cycles after accept; a second st_valid held high is accepted the cycle after done.
- st_size=11 at st_addr=0x00000001 → err_code=10 (not 01); with MAX_WAIT=4:
  - No ack → mem_req high 4 cycles, then err_code=11.
  - Ack in the 4th cycle → done, no err.
- rst_n pulsed low mid-REQ (asynchronous, between edges) → mem_req=0 and st_ready=1 immediately; no done or err pulse follows; the next store proceeds normally.

Source files
------------

// File: rtl/store_unit.sv
// Store path: narrows a register value to byte/halfword/word, replicates it
// across byte lanes and performs a req/ack write to data memory with timeout.
module store_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] EC_NONE     = 2'b00;
  localparam logic [1:0] EC_MISALIGN = 2'b01;
  localparam logic [1:0] EC_SIZE     = 2'b10;
  localparam logic [1:0] EC_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t           r_state;
  logic             r_ready;
  logic             r_req;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_code;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_code;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic             w_accept;

  assign w_accept = st_valid & r_ready;

  // Legality check, lane enables and lane-replicated data for the incoming store.
  // A reserved size is reported ahead of any alignment problem.
  always_comb begin
    w_code  = EC_NONE;
    w_be    = 4'b0000;
    w_wdata = 32'h0000_0000;
    case (st_size)
      SZ_BYTE: begin
        w_be    = 4'b1000 >> st_addr[1:0];
        w_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        w_be    = st_addr[1] ? 4'b0011 : 4'b1100;
        w_wdata = {2{st_data[15:0]}};
        if (st_addr[0]) w_code = EC_MISALIGN;
      end
      SZ_WORD: begin
        w_be    = 4'b1111;
        w_wdata = st_data;
        if (st_addr[1:0] != 2'b00) w_code = EC_MISALIGN;
      end
      default: w_code = EC_SIZE;
    endcase
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_req   <= 1'b0;
      r_addr  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
      r_be    <= 4'b0000;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= EC_NONE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            if (w_code != EC_NONE) begin
              r_state <= S_RESP;
              r_err   <= 1'b1;
              r_code  <= w_code;
            end else begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
              r_addr  <= {st_addr[31:2], 2'b00};
              r_wdata <= w_wdata;
              r_be    <= w_be;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_state <= S_RESP;
            r_req   <= 1'b0;
            r_be    <= 4'b0000;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            // Final allowed cycle without an ack: abort the write.
            if (r_cnt >= LAST_WAIT) begin
              r_state <= S_RESP;
              r_req   <= 1'b0;
              r_be    <= 4'b0000;
              r_err   <= 1'b1;
              r_code  <= EC_TIMEOUT;
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_code  <= EC_NONE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_req   <= 1'b0;
          r_be    <= 4'b0000;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_code  <= EC_NONE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign st_ready  = r_ready;
  assign mem_req   = r_req;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_be    = r_be;
  assign done      = r_done;
  assign err       = r_err;
  assign err_code  = r_code;

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed vector table, back-to-back and
// reset corner cases, then randomized stores against a transaction-level model.
module tb_store_unit;

  localparam int unsigned MW = 4;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int n_vec;
  int n_bad;

  store_unit #(.MAX_WAIT(MW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_size  (st_size),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_ack  (mem_ack),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          ack_dly;   // REQ cycle index carrying mem_ack; >= MW means never
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_code;  // 0 = done, otherwise the err_code of the err pulse
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference rules, written from the byte-lane arithmetic.
  function automatic logic [1:0] ref_code(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 2'd2;
    if (sz == 2'd1 && a[0]) return 2'd1;
    if (sz == 2'd2 && (a % 4) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [1:0] sz);
    int lane;
    lane = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << (3 - lane));
    if (sz == 2'd1) return (lane >= 2) ? 4'd3 : 4'd12;
    return 4'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return 32'(d % 256) * 32'h0101_0101;
    if (sz == 2'd1) return 32'(d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  // Run one store from an IDLE cycle through to the following IDLE cycle.
  task automatic do_store(input vec_t v, input bit keep_valid);
    logic [31:0] exp_addr;
    bit          finished;
    exp_addr = v.addr & 32'hFFFF_FFFC;
    st_addr  = v.addr;
    st_data  = v.data;
    st_size  = v.size;
    st_valid = 1'b1;
    chk("ready_idle", 32'(st_ready), 32'd1);
    step();
    st_valid = 1'b0;
    if (v.exp_code == 2'd1 || v.exp_code == 2'd2) begin
      chk("req_illegal", 32'(mem_req), 32'd0);
    end else begin
      finished = 1'b0;
      for (int k = 0; k < int'(MW) && !finished; k++) begin
        chk("req_high", 32'(mem_req), 32'd1);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, v.exp_wdata);
        chk("mem_be", 32'(mem_be), 32'(v.exp_be));
        chk("busy", {29'd0, st_ready, done, err}, 32'd0);
        mem_ack = (k == v.ack_dly);
        step();
        if (mem_ack) finished = 1'b1;
        mem_ack = 1'b0;
      end
    end
    chk("resp_done", 32'(done), (v.exp_code == 2'd0) ? 32'd1 : 32'd0);
    chk("resp_err", 32'(err), (v.exp_code != 2'd0) ? 32'd1 : 32'd0);
    chk("resp_code", 32'(err_code), 32'(v.exp_code));
    chk("resp_quiet", {28'd0, mem_be}, {31'd0, st_ready});
    chk("resp_req", 32'(mem_req), 32'd0);
    if (keep_valid) st_valid = 1'b1;
    step();
    chk("idle_state", {26'd0, st_ready, mem_req, mem_be == 4'd0, done, err, 1'b0}, 32'b101000);
  endtask

  vec_t tbl [8];
  vec_t rv;

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_size  = '0;
    mem_ack  = 1'b0;

    tbl[0] = '{32'h0000_1003, 32'hAABB_CCDD, 2'd0, 2,  4'b0001, 32'hDDDD_DDDD, 2'd0};
    tbl[1] = '{32'h0000_2002, 32'h1234_5678, 2'd1, 0,  4'b0011, 32'h5678_5678, 2'd0};
    tbl[2] = '{32'h0000_2001, 32'h1234_5678, 2'd1, 0,  4'b0000, 32'h0,         2'd1};
    tbl[3] = '{32'h0000_3000, 32'hCAFE_F00D, 2'd2, 0,  4'b1111, 32'hCAFE_F00D, 2'd0};
    tbl[4] = '{32'h0000_0001, 32'h0000_0000, 2'd3, 0,  4'b0000, 32'h0,         2'd2};
    tbl[5] = '{32'h0000_4000, 32'h0BAD_BEEF, 2'd2, 99, 4'b1111, 32'h0BAD_BEEF, 2'd3};
    tbl[6] = '{32'h0000_4004, 32'h1357_9BDF, 2'd2, 3,  4'b1111, 32'h1357_9BDF, 2'd0};
    tbl[7] = '{32'h0000_0010, 32'h0000_0055, 2'd0, 1,  4'b1000, 32'h5555_5555, 2'd0};

    #12;
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_flags", {26'd0, mem_be, done, err}, 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) do_store(tbl[i], 1'b0);

    // st_valid held through RESP: ignored there, accepted in the next IDLE cycle.
    do_store(tbl[3], 1'b1);
    do_store(tbl[3], 1'b0);

    // mem_ack while idle must be ignored.
    mem_ack = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    chk("idle_ack", {29'd0, mem_req, done, err}, 32'd0);

    // Asynchronous reset in the middle of a REQ.
    st_addr  = 32'h0000_5000;
    st_data  = 32'h0123_4567;
    st_size  = 2'd2;
    st_valid = 1'b1;
    step();
    st_valid = 1'b0;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", 32'(mem_req), 32'd0);
    chk("async_ready", 32'(st_ready), 32'd1);
    chk("async_be", 32'(mem_be), 32'd0);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_1", {29'd0, st_ready, done, err}, 32'b100);
    step();
    chk("post_rst_2", {29'd0, mem_req, done, err}, 32'd0);
    do_store(tbl[1], 1'b0);

    // Randomized stores against the reference rules.
    for (int i = 0; i < 60; i++) begin
      rv.addr    = $urandom;
      rv.data    = $urandom;
      rv.size    = 2'($urandom_range(0, 3));
      rv.ack_dly = int'($urandom_range(0, 5));
      rv.exp_be  = ref_be(rv.addr, rv.size);
      rv.exp_wdata = ref_wdata(rv.data, rv.size);
      rv.exp_code  = ref_code(rv.addr, rv.size);
      if (rv.exp_code == 2'd0 && rv.ack_dly >= int'(MW)) rv.exp_code = 2'd3;
      do_store(rv, 1'b0);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        mem_ack = 1'($urandom_range(0, 1));
        step();
        mem_ack = 1'b0;
        chk("rand_idle", {29'd0, st_ready, mem_req, done | err}, 32'b100);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
